pwm_output_matrix: RTL and testbench
====================================

// Module: pwm_output_matrix
// PURPOSE
//  Parametrised successor of the single-PWM analog/digital output stage.
//  - Contains N_PWM independent PWM generators, each with its own period, duty and polarity.
//  - A per-pin 4-bit selector routes each of N_OUT pins to the digital DOUT bit, to any generator, or to a forced-low level.
//  - Sits on the memory-mapped peripheral bus; drives the board LEDs and output pins.
// PARAMETERS
//  N_OUT  20  number of output pins (1..32)
//  N_PWM  4   number of PWM generators (1..8)
//  CNT_W  16  PWM counter / period / duty width (2..32)
//  ADDR_W 5   word-address width of the register window
// PORTS
//  clk   in  1       single clock; all state updates on posedge
//  rst_n in  1       asynchronous, active-low reset
//  addr  in  ADDR_W  register word address
//  WD    in  32      write data
//  WE    in  1       write enable, one write per cycle
//  RD    out 32      read data, combinational on addr
//  DOUT  in  N_OUT   digital value per pin, from the GPIO peripheral
//  out   out N_OUT   pin outputs
//  irq   out 1       PWM wrap interrupt; tied 0 without PWM_IRQ_EN
// BEHAVIOUR
//  Register map (word addresses):
//   0x00-0x03 SEL: 8 fields of 4 bits per word; pin i is addr i/8, bits 4*(i%8)+:4.
//   0x04      CTRL: [N_PWM-1:0] enable, [8+N_PWM-1:8] polarity.
//   0x08+2k   PERIOD_k, shadow.
//   0x09+2k   DUTY_k, shadow.
//   0x18      IRQ_STAT.
//   0x19      IRQ_MASK.
//   Unmapped reads return 0; unmapped writes are ignored.
//   RD returns SEL, CTRL and the shadow PERIOD/DUTY values; unused upper bits read 0.
//  Reset: every register, counter and active copy clears to 0; pwm_q = 0; out = 0 (SEL = 0 selects DOUT, which is 0 at reset).
//  SEL field s for pin i:
//   - s = 0: out[i] = DOUT[i].
//   - 1 <= s <= N_PWM: out[i] = pwm_q[s-1].
//   - s > N_PWM: out[i] = 0.
//   - Purely combinational from registered state; a new SEL value takes effect the cycle after the write.
//  Generator k while disabled:
//   - cnt = 0.
//   - Active period/duty copy the shadow registers every cycle.
//   - pwm_q[k] = pol[k].
//  Generator k while enabled, every cycle:
//   - If cnt == per_act, then cnt <= 0 and per_act/duty_act <= shadow (boundary).
//   - Otherwise cnt <= cnt + 1.
//   - pwm_q[k] <= (cnt < duty_act) ^ pol[k]; registered, one-cycle latency from cnt.
//  Arithmetic and boundary rules:
//   - Waveform length is per_act + 1 cycles.
//   - duty 0 gives constantly inactive; duty > per_act gives constantly active.
//   - per_act = 0 gives a boundary on every cycle.
//  Shadow write in the same cycle as a boundary: the active copy loads the OLD shadow value; the new value applies at the following boundary.
//  Enable 0->1: counting starts from cnt = 0 with the current shadow values.
//  Enable 1->0: cnt is cleared the next cycle.
//  Reset asserted mid-period: immediate asynchronous clear of all state; no pending write survives.
// CONFIGURATION
//  PWM_IRQ_EN defined:
//   - IRQ_STAT[k] is set at every boundary of generator k.
//   - Writing 1 to a bit clears it; a set in the same cycle as a clear wins.
//   - irq = |(IRQ_STAT & IRQ_MASK), registered state, no extra latency.
//  PWM_IRQ_EN undefined:
//   - 0x18/0x19 read 0 and ignore writes.
//   - irq = 0; no status/mask flops exist.
// STRUCTURE
//  Include file pwm_output_matrix_defs.vh holds:
//   - address localparams (SEL_BASE, CTRL_ADDR, PER_BASE, IRQ_STAT_ADDR, IRQ_MASK_ADDR);
//   - SEL field width 4 and SEL_DIGITAL = 0.
//  Sub-module pwm_channel (generated N_PWM times):
//   - ports: clk, rst_n, en, pol, per_sh, duty_sh, pwm, wrap.
//   - contains the counter, active copies and compare.
//  Top level holds the register file, read mux, pin mux and IRQ logic.
// TESTING
//  1. Reset value: after reset with DOUT = 20'hFFFFF, out = DOUT; RD at 0x04 and 0x08 reads 0.
//  2. Basic waveform: PERIOD0 = 9, DUTY0 = 3, CTRL = 1, SEL pin0 = 1 -> out[0] high 3 / low 7 cycles, repeating every 10 cycles.
//  3. Polarity and limits on gen 0:
//     - CTRL = 0x101 -> out[0] is the inverse of test 2.
//     - DUTY0 = 0 -> constantly low (pol 0).
//     - DUTY0 = 12 with PERIOD0 = 9 -> constantly high.
//  4. Shadow timing: mid-period write DUTY0 = 7 -> current period keeps duty 3; the next period shows 7. A write exactly on the boundary cycle applies one period later.
//  5. Mux and invalid select:
//     - SEL pin19 = 4 with gen 3 at PERIOD = 1, DUTY = 1 -> 50% square on out[19].
//     - SEL pin19 = 9 -> out[19] = 0.
//     - SEL pin19 = 0 -> out[19] follows DOUT[19].
//  6. IRQ (PWM_IRQ_EN):
//     - IRQ_MASK = 1, PERIOD0 = 4 -> irq rises after the first boundary.
//     - Write IRQ_STAT = 1 on a boundary cycle -> the bit stays set.
//     - Rerun without the macro -> irq stays 0.

Source files
------------

// File: rtl/pwm_output_matrix_pkg.sv
// Shared register-window addresses and pin-selector encoding for pwm_output_matrix.
// These are the address/selector constants the rest of the block imports in place of a separate defs include.
package pwm_output_matrix_pkg;
  localparam int SEL_W          = 4;
  localparam logic [SEL_W-1:0] SEL_DIGITAL = 4'd0;
  localparam int SEL_PER_WORD   = 8;

  localparam int SEL_BASE       = 'h00;
  localparam int CTRL_ADDR      = 'h04;
  localparam int PER_BASE       = 'h08;
  localparam int IRQ_STAT_ADDR  = 'h18;
  localparam int IRQ_MASK_ADDR  = 'h19;
  localparam int POL_LSB        = 8;
endpackage

// File: rtl/pwm_output_matrix_channel.sv
// One PWM generator: wrap-around counter, active period/duty copies and compare.
// Active copies reload from the shadows while disabled and at each boundary.
module pwm_channel #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             pol,
  input  logic [CNT_W-1:0] per_sh,
  input  logic [CNT_W-1:0] duty_sh,
  output logic             pwm,
  output logic             wrap
);
  logic [CNT_W-1:0] cnt_q, per_q, duty_q;
  logic             pwm_q;

  assign wrap = en && (cnt_q == per_q);
  assign pwm  = pwm_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      per_q  <= '0;
      duty_q <= '0;
      pwm_q  <= 1'b0;
    end else if (!en) begin
      cnt_q  <= '0;
      per_q  <= per_sh;
      duty_q <= duty_sh;
      pwm_q  <= pol;
    end else begin
      // Shadow sampled at this edge is the pre-write value, so a same-cycle write waits a period.
      if (wrap) begin
        cnt_q  <= '0;
        per_q  <= per_sh;
        duty_q <= duty_sh;
      end else begin
        cnt_q  <= cnt_q + 1'b1;
      end
      pwm_q <= (cnt_q < duty_q) ^ pol;
    end
  end
endmodule

// File: rtl/pwm_output_matrix.sv
// Register file, read mux, pin mux and optional wrap interrupt for N_PWM generators.
// Optional feature macro: PWM_IRQ_EN (adds IRQ_STAT/IRQ_MASK and drives irq).
module pwm_output_matrix
  import pwm_output_matrix_pkg::*;
#(
  parameter int N_OUT  = 20,
  parameter int N_PWM  = 4,
  parameter int CNT_W  = 16,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       WD,
  input  logic              WE,
  output logic [31:0]       RD,
  input  logic [N_OUT-1:0]  DOUT,
  output logic [N_OUT-1:0]  out,
  output logic              irq
);
  logic [SEL_W-1:0] sel_q     [N_OUT];
  logic [N_PWM-1:0] en_q, pol_q;
  logic [CNT_W-1:0] per_sh_q  [N_PWM];
  logic [CNT_W-1:0] duty_sh_q [N_PWM];
  logic [N_PWM-1:0] pwm_w, wrap_w;
  logic             unused_bits;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_OUT; i++) sel_q[i] <= SEL_DIGITAL;
      en_q  <= '0;
      pol_q <= '0;
      for (int k = 0; k < N_PWM; k++) begin
        per_sh_q[k]  <= '0;
        duty_sh_q[k] <= '0;
      end
    end else if (WE) begin
      for (int i = 0; i < N_OUT; i++)
        if (addr == ADDR_W'(SEL_BASE + i / SEL_PER_WORD))
          sel_q[i] <= WD[SEL_W*(i % SEL_PER_WORD) +: SEL_W];
      if (addr == ADDR_W'(CTRL_ADDR)) begin
        en_q  <= WD[N_PWM-1:0];
        pol_q <= WD[POL_LSB +: N_PWM];
      end
      for (int k = 0; k < N_PWM; k++) begin
        if (addr == ADDR_W'(PER_BASE + 2*k))     per_sh_q[k]  <= WD[CNT_W-1:0];
        if (addr == ADDR_W'(PER_BASE + 2*k + 1)) duty_sh_q[k] <= WD[CNT_W-1:0];
      end
    end
  end

  for (genvar g = 0; g < N_PWM; g++) begin : g_gen
    pwm_channel #(.CNT_W(CNT_W)) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en_q[g]),
      .pol     (pol_q[g]),
      .per_sh  (per_sh_q[g]),
      .duty_sh (duty_sh_q[g]),
      .pwm     (pwm_w[g]),
      .wrap    (wrap_w[g])
    );
  end

`ifdef PWM_IRQ_EN
  logic [N_PWM-1:0] stat_q, mask_q, clr_w;

  assign clr_w = (WE && addr == ADDR_W'(IRQ_STAT_ADDR)) ? WD[N_PWM-1:0] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_q <= '0;
      mask_q <= '0;
    end else begin
      stat_q <= (stat_q & ~clr_w) | wrap_w;
      if (WE && addr == ADDR_W'(IRQ_MASK_ADDR)) mask_q <= WD[N_PWM-1:0];
    end
  end

  assign irq = |(stat_q & mask_q);
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    RD = '0;
    for (int i = 0; i < N_OUT; i++)
      if (addr == ADDR_W'(SEL_BASE + i / SEL_PER_WORD))
        RD[SEL_W*(i % SEL_PER_WORD) +: SEL_W] = sel_q[i];
    if (addr == ADDR_W'(CTRL_ADDR)) begin
      RD[N_PWM-1:0]         = en_q;
      RD[POL_LSB +: N_PWM]  = pol_q;
    end
    for (int k = 0; k < N_PWM; k++) begin
      if (addr == ADDR_W'(PER_BASE + 2*k))     RD[CNT_W-1:0] = per_sh_q[k];
      if (addr == ADDR_W'(PER_BASE + 2*k + 1)) RD[CNT_W-1:0] = duty_sh_q[k];
    end
`ifdef PWM_IRQ_EN
    if (addr == ADDR_W'(IRQ_STAT_ADDR)) RD[N_PWM-1:0] = stat_q;
    if (addr == ADDR_W'(IRQ_MASK_ADDR)) RD[N_PWM-1:0] = mask_q;
`endif
  end

  // Selector values above N_PWM fall through to a forced low.
  always_comb begin
    out = '0;
    for (int i = 0; i < N_OUT; i++) begin
      if (sel_q[i] == SEL_DIGITAL) out[i] = DOUT[i];
      for (int k = 0; k < N_PWM; k++)
        if (sel_q[i] == SEL_W'(k + 1)) out[i] = pwm_w[k];
    end
  end

  assign unused_bits = ^{WD, wrap_w};
endmodule

// File: tb/tb_pwm_output_matrix.sv
// Self-checking bench for pwm_output_matrix: register table, directed waveform/corner sequences,
// and a randomized run against a cycle-stamp reference model. Honors PWM_IRQ_EN like the design.
module tb_pwm_output_matrix;
  localparam int N_OUT = 20, N_PWM = 4, CNT_W = 16, ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       WD, RD;
  logic              WE;
  logic [N_OUT-1:0]  DOUT, out;
  logic              irq;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pwm_output_matrix #(.N_OUT(N_OUT), .N_PWM(N_PWM), .CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .WD(WD), .WE(WE), .RD(RD),
    .DOUT(DOUT), .out(out), .irq(irq)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    addr = a; WD = d; WE = 1'b1;
    tick();
    WE = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [ADDR_W-1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(name, RD, exp);
  endtask

  task automatic do_reset();
    WE = 1'b0; addr = '0; WD = '0;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  // ---------------- reference model (cycle stamps, not counters) ----------------
  int          m_sel [N_OUT];
  bit [3:0]    m_en, m_pol, m_pwm, m_stat, m_mask;
  int          m_per [N_PWM], m_duty [N_PWM], m_pa [N_PWM], m_da [N_PWM];
  longint      m_start [N_PWM];
  longint      cyc;

  function automatic void model_reset();
    for (int i = 0; i < N_OUT; i++) m_sel[i] = 0;
    m_en = 0; m_pol = 0; m_pwm = 0; m_stat = 0; m_mask = 0;
    for (int k = 0; k < N_PWM; k++) begin
      m_per[k] = 0; m_duty[k] = 0; m_pa[k] = 0; m_da[k] = 0; m_start[k] = 0;
    end
    cyc = 0;
  endfunction

  // Advance the model across one rising edge given the inputs presented before it.
  function automatic void model_step(input bit we, input int a, input logic [31:0] d);
    bit [3:0] bnd = 0;
    bit [3:0] npwm = 0;
    for (int k = 0; k < N_PWM; k++) begin
      if (!m_en[k]) begin
        npwm[k] = m_pol[k];
        m_pa[k] = m_per[k]; m_da[k] = m_duty[k];
        m_start[k] = cyc + 1;
      end else begin
        longint ph = cyc - m_start[k];
        npwm[k] = (ph < m_da[k]) ^ m_pol[k];
        if (ph >= m_pa[k]) begin
          bnd[k] = 1;
          m_start[k] = cyc + 1;
          m_pa[k] = m_per[k]; m_da[k] = m_duty[k];
        end
      end
    end
    m_pwm = npwm;
`ifdef PWM_IRQ_EN
    m_stat = (m_stat & ~((we && a == 24) ? d[3:0] : 4'h0)) | bnd;
`endif
    if (we) begin
      if (a < 4) begin
        for (int i = 0; i < N_OUT; i++)
          if (i / 8 == a) m_sel[i] = int'((d >> (4 * (i % 8))) & 32'hF);
      end else if (a == 4) begin
        m_en = d[3:0]; m_pol = d[11:8];
      end else if (a >= 8 && a < 8 + 2 * N_PWM) begin
        if (a % 2 == 1) m_duty[(a - 8) / 2] = int'(d & 32'hFFFF);
        else            m_per[(a - 8) / 2]  = int'(d & 32'hFFFF);
      end
`ifdef PWM_IRQ_EN
      else if (a == 25) m_mask = d[3:0];
`endif
    end
    cyc++;
  endfunction

  function automatic logic [N_OUT-1:0] model_out(input logic [N_OUT-1:0] dout);
    logic [N_OUT-1:0] o = '0;
    for (int i = 0; i < N_OUT; i++) begin
      if (m_sel[i] == 0) o[i] = dout[i];
      else if (m_sel[i] <= N_PWM) o[i] = m_pwm[m_sel[i] - 1];
    end
    return o;
  endfunction

  function automatic logic [31:0] model_read(input int a);
    logic [31:0] r = '0;
    if (a < 4) begin
      for (int i = 0; i < N_OUT; i++)
        if (i / 8 == a) r = r | (32'(m_sel[i]) << (4 * (i % 8)));
    end else if (a == 4) r = {20'h0, m_pol, 4'h0, m_en};
    else if (a >= 8 && a < 8 + 2 * N_PWM)
      r = (a % 2 == 1) ? 32'(m_duty[(a - 8) / 2]) : 32'(m_per[(a - 8) / 2]);
`ifdef PWM_IRQ_EN
    else if (a == 24) r = 32'(m_stat);
    else if (a == 25) r = 32'(m_mask);
`endif
    return r;
  endfunction

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [31:0]       d;
    logic [31:0]       exp;
  } vec_t;

  vec_t vt [10];
  logic [31:0] mask_rb;
  logic exp_bit;
  int duty_now;

  initial begin
`ifdef PWM_IRQ_EN
    mask_rb = 32'h0000_000F;
`else
    mask_rb = 32'h0;
`endif
    vt[0] = '{5'h00, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vt[1] = '{5'h02, 32'hFFFF_FFFF, 32'h0000_FFFF};
    vt[2] = '{5'h03, 32'hFFFF_FFFF, 32'h0000_0000};
    vt[3] = '{5'h04, 32'hFFFF_FFFF, 32'h0000_0F0F};
    vt[4] = '{5'h08, 32'hFFFF_FFFF, 32'h0000_FFFF};
    vt[5] = '{5'h0F, 32'h1234_5678, 32'h0000_5678};
    vt[6] = '{5'h10, 32'hFFFF_FFFF, 32'h0000_0000};
    vt[7] = '{5'h05, 32'hFFFF_FFFF, 32'h0000_0000};
    vt[8] = '{5'h1F, 32'hFFFF_FFFF, 32'h0000_0000};
    vt[9] = '{5'h19, 32'hFFFF_FFFF, mask_rb};

    // Reset values
    DOUT = 20'hFFFFF;
    do_reset();
    chk("reset_out", 32'(out), 32'h000F_FFFF);
    rd_chk("reset_ctrl", 5'h04, 32'h0);
    rd_chk("reset_per0", 5'h08, 32'h0);
    chk("reset_irq", 32'(irq), 32'h0);

    // Register table
    for (int i = 0; i < 10; i++) begin
      wr(vt[i].a, vt[i].d);
      rd_chk($sformatf("reg_%02h", vt[i].a), vt[i].a, vt[i].exp);
    end

    // Basic waveform, period 10, duty 3
    do_reset();
    DOUT = 20'h0;
    wr(5'h08, 9); wr(5'h09, 3); wr(5'h00, 32'h1); wr(5'h04, 32'h1);
    for (int j = 0; j < 20; j++) begin
      tick();
      chk($sformatf("basic_j%0d", j), 32'(out[0]), 32'((j % 10) < 3));
    end

    // Asynchronous reset mid-period
    DOUT = 20'h5A5A5;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out", 32'(out), 32'h0005_A5A5);
    rd_chk("async_rst_ctrl", 5'h04, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("async_rst_sel", 32'(out), 32'h0005_A5A5);

    // Polarity and duty limits
    wr(5'h08, 9); wr(5'h09, 3); wr(5'h00, 32'h1); wr(5'h04, 32'h101);
    for (int j = 0; j < 20; j++) begin
      tick();
      chk($sformatf("pol_j%0d", j), 32'(out[0]), 32'(!((j % 10) < 3)));
    end
    wr(5'h04, 0); wr(5'h09, 0); wr(5'h04, 1);
    for (int j = 0; j < 15; j++) begin
      tick();
      chk($sformatf("duty0_j%0d", j), 32'(out[0]), 32'h0);
    end
    wr(5'h04, 0); wr(5'h09, 12); wr(5'h04, 1);
    for (int j = 0; j < 15; j++) begin
      tick();
      chk($sformatf("dutybig_j%0d", j), 32'(out[0]), 32'h1);
    end

    // Shadow timing: mid-period write, then a write on the boundary cycle
    wr(5'h04, 0); wr(5'h09, 3); wr(5'h04, 1);
    for (int j = 0; j < 40; j++) begin
      if (j == 4)  begin addr = 5'h09; WD = 7; WE = 1'b1; end
      if (j == 19) begin addr = 5'h09; WD = 5; WE = 1'b1; end
      tick();
      WE = 1'b0;
      duty_now = (j < 10) ? 3 : (j < 30) ? 7 : 5;
      chk($sformatf("shadow_j%0d", j), 32'(out[0]), 32'((j % 10) < duty_now));
    end

    // Pin mux and invalid selector
    do_reset();
    DOUT = 20'h0;
    wr(5'h0E, 1); wr(5'h0F, 1); wr(5'h02, 32'h0000_4000); wr(5'h04, 32'h8);
    for (int j = 0; j < 8; j++) begin
      tick();
      chk($sformatf("mux_sq_j%0d", j), 32'(out[19]), 32'((j % 2) == 0));
    end
    wr(5'h02, 32'h0000_9000);
    for (int j = 0; j < 4; j++) begin
      tick();
      chk($sformatf("mux_inv_j%0d", j), 32'(out[19]), 32'h0);
    end
    wr(5'h02, 32'h0);
    for (int j = 0; j < 4; j++) begin
      DOUT[19] = j[0];
      #1;
      chk($sformatf("mux_dout_j%0d", j), 32'(out[19]), 32'(j[0]));
      tick();
    end

    // Wrap interrupt; expectations collapse to 0 when the feature is compiled out
    do_reset();
    wr(5'h19, 1); wr(5'h08, 4); wr(5'h09, 2); wr(5'h04, 1);
    for (int j = 0; j < 16; j++) begin
      if (j == 6 || j == 9) begin addr = 5'h18; WD = 1; WE = 1'b1; end
      tick();
      WE = 1'b0;
      exp_bit = (j >= 4 && j < 6) || (j >= 9);
`ifndef PWM_IRQ_EN
      exp_bit = 1'b0;
`endif
      chk($sformatf("irq_j%0d", j), 32'(irq), 32'(exp_bit));
    end
    rd_chk("irq_stat_rd", 5'h18, 32'(exp_bit));

    // Randomized run against the reference model
    do_reset();
    model_reset();
    begin
      int pick;
      int a;
      for (int n = 0; n < 3000; n++) begin
        DOUT = 20'($urandom);
        pick = $urandom_range(0, 9);
        case (pick)
          0, 1: a = $urandom_range(0, 3);
          2:    a = 4;
          3, 4, 5, 6: a = $urandom_range(8, 15);
          7:    a = $urandom_range(24, 25);
          default: a = $urandom_range(0, 31);
        endcase
        addr = 5'(a);
        WE = ($urandom_range(0, 3) == 0);
        WD = $urandom;
        if (a >= 8 && a < 16 && $urandom_range(0, 7) != 0) WD = $urandom_range(0, 12);
        #1;
        chk("rand_rd", RD, model_read(a));
        model_step(WE, a, WD);
        tick();
        chk("rand_out", 32'(out), 32'(model_out(DOUT)));
`ifdef PWM_IRQ_EN
        chk("rand_irq", 32'(irq), 32'(|(m_stat & m_mask)));
`else
        chk("rand_irq", 32'(irq), 32'h0);
`endif
      end
    end
    WE = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
